mm_wr_slave_fifo: RTL

MM_WR_SLAVE_FIFO -- requirements
Module: mm_wr_slave_fifo

---
 rtl/mm_wr_slave_fifo.sv | 119 +++++++++++
 1 files changed

// File: rtl/mm_wr_slave_fifo.sv
// rtl/mm_wr_slave_fifo.sv - Avalon-MM write slave feeding a FIFO plus output register
// Accepted writes are queued as {address, writedata} and presented on a valid/ready conduit.
module mm_wr_slave_fifo #(
  parameter int DEPTH = 8
) (
  input  logic        csi_clk,
  input  logic        rsi_reset_n,
  input  logic [7:0]  avs_s0_address,
  input  logic        avs_s0_write,
  input  logic [7:0]  avs_s0_writedata,
  input  logic        avs_s0_read,
  output logic [7:0]  avs_s0_readdata,
  output logic        avs_s0_waitrequest,
  output logic [7:0]  coe_c0_addr,
  output logic [7:0]  coe_c0_data,
  output logic        coe_c0_valid,
  input  logic        coe_c0_ready,
  output logic [15:0] coe_c0_total
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   total_q, total_d;
  out_state_e    state_q;
  logic [7:0]    addr_q, data_q;

  logic          fifo_full, fifo_empty;
  logic          push, pop;
  logic [15:0]   head;
  logic [7:0]    status;

  assign fifo_full  = (count_q == CW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];

  // A pop in the same cycle deliberately does not release the stall.
  assign avs_s0_waitrequest = avs_s0_write & fifo_full;
  assign push = avs_s0_write & ~fifo_full;
  assign pop  = ~fifo_empty & ((state_q == OUT_EMPTY) | coe_c0_ready);

  assign status          = {fifo_full, fifo_empty, (state_q == OUT_FULL), 5'(count_q)};
  assign avs_s0_readdata = avs_s0_read ? status : 8'h00;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    total_d  = push ? total_q + 16'd1   : total_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; pointers and count define which entries are live.
  always_ff @(posedge csi_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {avs_s0_address, avs_s0_writedata};
    end
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      total_q  <= 16'h0000;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      total_q  <= total_d;
    end
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state_q <= OUT_EMPTY;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      case (state_q)
        OUT_EMPTY: begin
          if (pop) begin
            {addr_q, data_q} <= head;
            state_q          <= OUT_FULL;
          end
        end
        OUT_FULL: begin
          if (coe_c0_ready) begin
            if (pop) begin
              {addr_q, data_q} <= head;
            end else begin
              state_q <= OUT_EMPTY;
            end
          end
        end
        default: state_q <= OUT_EMPTY;
      endcase
    end
  end

  assign coe_c0_valid = (state_q == OUT_FULL);
  assign coe_c0_addr  = addr_q;
  assign coe_c0_data  = data_q;
  assign coe_c0_total = total_q;

endmodule
